// File: rtl/noc_output_arbiter.sv
// Output-port scheduler: round-robin over NUM_IN buffers, wormhole lock per packet, 1-cycle flit latency.
// Backpressure: pops only while the registered downstream credit count is non-zero; stalls hold the lock.
module noc_output_arbiter #(
    parameter int NUM_IN  = 5,
    parameter int CREDITS = 4,
    parameter int DW      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IN-1:0]    valid_i,
    input  logic [NUM_IN*DW-1:0] data_i,
    output logic [NUM_IN-1:0]    pop_o,
    output logic                 enable_o,
    output logic [DW-1:0]        data_o,
    input  logic                 credit_i,
    output logic                 err_o
);
    localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CW = $clog2(CREDITS + 1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   credit_cnt_q, credit_cnt_d;
    logic            enable_q;
    logic [DW-1:0]   data_q, data_d;
    logic            err_q, err_d;

    logic            can_send;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            send;
    logic [IW-1:0]   gnt_idx;
    logic [DW-1:0]   gnt_flit;
    logic            gnt_tail;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(NUM_IN - 1)) ? '0 : idx + IW'(1);
    endfunction

    assign can_send = (credit_cnt_q != '0);

    // First requester at or after rr_ptr, wrapping past NUM_IN-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = rr_ptr_q;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!win_found && valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = next_idx(cand);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // FSM next state: a tail flit releases the port and moves the pointer past the sender.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (send) begin
            if (gnt_tail) begin
                state_d  = IDLE;
                rr_ptr_d = next_idx(gnt_idx);
            end else begin
                state_d  = LOCKED;
                owner_d  = gnt_idx;
            end
        end
    end

    // FSM outputs: grant selection and pop; pop is held low while reset is asserted.
    always_comb begin
        send     = 1'b0;
        gnt_idx  = '0;
        gnt_flit = '0;
        pop_o    = '0;
        unique case (state_q)
            IDLE: begin
                if (can_send && win_found) begin
                    send    = 1'b1;
                    gnt_idx = win_idx;
                end
            end
            LOCKED: begin
                if (can_send && valid_i[owner_q]) begin
                    send    = 1'b1;
                    gnt_idx = owner_q;
                end
            end
        endcase
        send = send & rst;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == IW'(i)) gnt_flit = data_i[i*DW +: DW];
        end
        if (send) pop_o[gnt_idx] = 1'b1;
    end

    assign gnt_tail = gnt_flit[DW-1];

    // A simultaneous send and credit return cancel; a credit arriving while full is an overflow.
    always_comb begin
        credit_cnt_d = credit_cnt_q;
        err_d        = err_q;
        data_d       = send ? gnt_flit : data_q;
        if (send && !credit_i) begin
            credit_cnt_d = credit_cnt_q - CW'(1);
        end else if (credit_i && !send) begin
            if (credit_cnt_q == CW'(CREDITS)) err_d = 1'b1;
            else                              credit_cnt_d = credit_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_cnt_q <= CW'(CREDITS);
            enable_q     <= 1'b0;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            credit_cnt_q <= credit_cnt_d;
            enable_q     <= send;
            data_q       <= data_d;
            err_q        <= err_d;
        end
    end

    assign enable_o = enable_q;
    assign data_o   = data_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: per-input flit queues feed the DUT, a scoreboard holds expected link flits.
// Round-robin table plus hand-written wormhole, bubble, credit and reset sequences.
module tb_noc_output_arbiter;
    localparam int NUM_IN  = 5;
    localparam int CREDITS = 4;
    localparam int DW      = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NUM_IN-1:0]    valid_i;
    logic [NUM_IN*DW-1:0] data_i;
    logic [NUM_IN-1:0]    pop_o;
    logic                 enable_o;
    logic [DW-1:0]        data_o;
    logic                 credit_i;
    logic                 err_o;

    noc_output_arbiter #(.NUM_IN(NUM_IN), .CREDITS(CREDITS), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .pop_o    (pop_o),
        .enable_o (enable_o),
        .data_o   (data_o),
        .credit_i (credit_i),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_IN-1:0] mask;
        int                exp_g;
    } vec_t;

    vec_t              tbl[10];
    logic [DW-1:0]     fifo[NUM_IN][$];
    logic [DW-1:0]     exp_q[$];
    int                gnt_log[$];
    int                want_g[$];
    logic [NUM_IN-1:0] bubble = '0;
    logic              auto_credit = 1'b0;
    logic              credit_once = 1'b0;
    int                seq = 0;
    int                n_cmp = 0;
    int                n_fail = 0;
    int                en_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int src, input bit tail);
        logic [7:0] s;
        seq++;
        s = seq[7:0];
        return {tail, 3'b000, src[3:0], s};
    endfunction

    task automatic clear_fifos();
        for (int i = 0; i < NUM_IN; i++) fifo[i].delete();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_IN; i++) begin
            valid_i[i]         = (fifo[i].size() > 0) && !bubble[i];
            data_i[i*DW +: DW] = (fifo[i].size() > 0) ? fifo[i][0] : '0;
        end
        credit_i    = credit_once || (auto_credit && enable_o);
        credit_once = 1'b0;
    endtask

    // One clock: sample pops mid-cycle, check the registered link one step after the edge.
    task automatic cyc();
        int g;
        g = -1;
        @(negedge clk);
        check("pop_onehot", ($countones(pop_o) > 1), 0);
        for (int i = 0; i < NUM_IN; i++) begin
            if (pop_o[i]) begin
                g = i;
                check("pop_of_valid", valid_i[i], 1);
                if (fifo[i].size() > 0) void'(fifo[i].pop_front());
            end
        end
        gnt_log.push_back(g);
        @(posedge clk);
        #1;
        check("enable_latency", enable_o, (g >= 0));
        if (enable_o) begin
            if (exp_q.size() == 0) check("sb_nonempty", (exp_q.size() != 0), 1);
            else                   check("data_o", data_o, exp_q.pop_front());
        end
        drive_inputs();
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, gnt_log.size(), want_g.size());
        for (int i = 0; i < want_g.size() && i < gnt_log.size(); i++)
            check($sformatf("%s_%0d", name, i), gnt_log[i], want_g[i]);
        gnt_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{5'b11111, 0};
        tbl[1] = '{5'b11111, 1};
        tbl[2] = '{5'b00001, 0};
        tbl[3] = '{5'b10100, 2};
        tbl[4] = '{5'b10100, 4};
        tbl[5] = '{5'b00000, -1};
        tbl[6] = '{5'b01010, 1};
        tbl[7] = '{5'b01010, 3};
        tbl[8] = '{5'b00011, 0};
        tbl[9] = '{5'b00011, 1};

        // Reset state with every input requesting
        valid_i  = '1;
        data_i   = '1;
        credit_i = 1'b0;
        #2;
        check("rst_pop", pop_o, 0);
        check("rst_enable", enable_o, 0);
        check("rst_data", data_o, 0);
        check("rst_err", err_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Continuous single-flit packets from all inputs
        clear_fifos();
        want_g.delete();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NUM_IN; k++) begin
                fifo[k].push_back(mk(k, 1'b1));
                exp_q.push_back(fifo[k][r]);
                want_g.push_back(k);
            end
        end
        auto_credit = 1'b1;
        drive_inputs();
        gnt_log.delete();
        en_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            cyc();
            if (enable_o) en_cnt++;
        end
        check("rr_stream_enables", en_cnt, 15);
        check_log("rr_stream");
        for (int c = 0; c < 4; c++) cyc();
        check("rr_stream_drained", exp_q.size(), 0);

        // Round-robin table, one single-flit request set per cycle
        for (int r = 0; r < 10; r++) begin
            clear_fifos();
            for (int i = 0; i < NUM_IN; i++)
                if (tbl[r].mask[i]) fifo[i].push_back(mk(i, 1'b1));
            if (tbl[r].exp_g >= 0) exp_q.push_back(fifo[tbl[r].exp_g][0]);
            drive_inputs();
            gnt_log.delete();
            cyc();
            check($sformatf("rr_row%0d", r), gnt_log[0], tbl[r].exp_g);
        end
        clear_fifos();
        drive_inputs();
        for (int c = 0; c < 4; c++) cyc();
        gnt_log.delete();
        check("table_drained", exp_q.size(), 0);

        // Wormhole lock: input 2 packet is contiguous, input 3 follows immediately
        fifo[2].push_back(16'h0011);
        fifo[2].push_back(16'h0022);
        fifo[2].push_back(16'h8033);
        fifo[3].push_back(16'h8301);
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0022);
        exp_q.push_back(16'h8033);
        exp_q.push_back(16'h8301);
        drive_inputs();
        for (int c = 0; c < 6; c++) cyc();
        want_g = '{2, 2, 2, 3, -1, -1};
        check_log("lock");
        check("lock_drained", exp_q.size(), 0);

        // Owner bubble mid-packet: nobody else is served until the owner's tail
        fifo[0].push_back(mk(0, 1'b0));
        fifo[0].push_back(mk(0, 1'b0));
        fifo[0].push_back(mk(0, 1'b1));
        fifo[1].push_back(mk(1, 1'b1));
        for (int k = 0; k < 3; k++) exp_q.push_back(fifo[0][k]);
        exp_q.push_back(fifo[1][0]);
        drive_inputs();
        cyc();
        bubble = 5'b00001;
        drive_inputs();
        en_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (enable_o) en_cnt++;
        end
        check("bubble_enables", en_cnt, 0);
        bubble = '0;
        drive_inputs();
        for (int c = 0; c < 5; c++) cyc();
        want_g = '{0, -1, -1, -1, 0, 0, 1, -1, -1};
        check_log("bubble");
        check("bubble_drained", exp_q.size(), 0);

        // Credit exhaustion, cancelling send+credit at count 1, single credit release
        auto_credit = 1'b0;
        for (int k = 0; k < 6; k++) begin
            fifo[1].push_back(mk(1, 1'b1));
            exp_q.push_back(fifo[1][k]);
        end
        drive_inputs();
        for (int c = 0; c < 3; c++) cyc();
        credit_once = 1'b1;
        drive_inputs();
        for (int c = 0; c < 7; c++) cyc();
        credit_once = 1'b1;
        drive_inputs();
        for (int c = 0; c < 4; c++) cyc();
        want_g = '{1, 1, 1, 1, 1, -1, -1, -1, -1, -1, -1, 1, -1, -1};
        check_log("credit");
        check("credit_drained", exp_q.size(), 0);

        // Refill to full, then one surplus credit sets the sticky error
        for (int c = 0; c < 4; c++) begin
            credit_once = 1'b1;
            drive_inputs();
            cyc();
        end
        check("err_before_overflow", err_o, 0);
        credit_once = 1'b1;
        drive_inputs();
        cyc();
        check("err_set", err_o, 1);
        for (int c = 0; c < 3; c++) cyc();
        check("err_sticky", err_o, 1);

        // Reset in the middle of a locked packet from input 3
        auto_credit = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fifo[3].push_back(mk(3, 1'b0));
            exp_q.push_back(fifo[3][k]);
        end
        drive_inputs();
        cyc();
        cyc();
        check("pre_reset_enable", enable_o, 1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_enable", enable_o, 0);
        check("midrst_err", err_o, 0);
        check("midrst_pop", pop_o, 0);
        check("midrst_data", data_o, 0);
        clear_fifos();
        exp_q.delete();
        gnt_log.delete();
        auto_credit = 1'b0;
        drive_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            fifo[0].push_back(mk(0, 1'b1));
            if (k < CREDITS) exp_q.push_back(fifo[0][k]);
        end
        drive_inputs();
        for (int c = 0; c < 7; c++) cyc();
        want_g = '{0, 0, 0, 0, -1, -1, -1};
        check_log("post_reset");
        check("post_reset_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
